// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the division operand sequencer.
//   DATA_W / TAG_W : operand/result and tag widths. The request struct and
//                    all datapath ports are sized from these.
//   DEPTH          : default request FIFO depth (power of two, >= 2).
//   state_t        : sequencer FSM states.
//   req_t          : one queued divide request.
package div_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] dividend;
        logic [DATA_W-1:0] divisor;
        logic [TAG_W-1:0]  tag;
    } req_t;

endpackage

// File: rtl/div_operand_sequencer_if.sv
// div_operand_sequencer_if: request, core and response signals of the
// division operand sequencer, bundled for connection.
//   slave  : sequencer view (drives o_*, samples i_*).
//   master : environment view (drives i_*, samples o_*).
//
// Handshakes (req and rsp): a transfer happens on a rising clock edge where
// valid and ready are both 1. Once valid is raised the sender holds valid and
// all payload fields stable until that transfer; ready may change freely and
// the sender never waits for ready before raising valid. The core side is not
// a handshake: o_core_start and i_core_done are single-cycle pulses.
interface div_operand_sequencer_if;

    // request channel
    logic                           i_req_valid;
    logic                           o_req_ready;
    logic [div_pkg::DATA_W-1:0]     i_req_dividend;
    logic [div_pkg::DATA_W-1:0]     i_req_divisor;
    logic [div_pkg::TAG_W-1:0]      i_req_tag;

    // core channel
    logic                           o_core_start;
    logic [div_pkg::DATA_W-1:0]     o_core_dividend;
    logic [div_pkg::DATA_W-1:0]     o_core_divisor;
    logic                           i_core_done;
    logic [div_pkg::DATA_W-1:0]     i_core_quotient;
    logic [div_pkg::DATA_W-1:0]     i_core_remainder;

    // response channel
    logic                           o_rsp_valid;
    logic                           i_rsp_ready;
    logic [div_pkg::DATA_W-1:0]     o_rsp_quotient;
    logic [div_pkg::DATA_W-1:0]     o_rsp_remainder;
    logic [div_pkg::TAG_W-1:0]      o_rsp_tag;
    logic                           o_rsp_div0;

    modport slave (
        input  i_req_valid, i_req_dividend, i_req_divisor, i_req_tag,
        output o_req_ready,
        output o_core_start, o_core_dividend, o_core_divisor,
        input  i_core_done, i_core_quotient, i_core_remainder,
        output o_rsp_valid, o_rsp_quotient, o_rsp_remainder, o_rsp_tag, o_rsp_div0,
        input  i_rsp_ready
    );

    modport master (
        output i_req_valid, i_req_dividend, i_req_divisor, i_req_tag,
        input  o_req_ready,
        input  o_core_start, o_core_dividend, o_core_divisor,
        output i_core_done, i_core_quotient, i_core_remainder,
        input  o_rsp_valid, o_rsp_quotient, o_rsp_remainder, o_rsp_tag, o_rsp_div0,
        output i_rsp_ready
    );

endinterface

// File: rtl/div_req_fifo.sv
// div_req_fifo: synchronous FIFO of divide requests.
//   clk, rst   : rising-edge clock, synchronous active-high reset (empties FIFO)
//   push/wdata : write one request (ignored when full)
//   pop/rdata  : rdata is the head entry; pop removes it (ignored when empty)
//   empty      : no entries stored
//   full_next  : FIFO will be full after this edge; lets the owner register
//                its ready flag without a combinational path from pop
// Pointers are log2(DEPTH) bits and wrap naturally; the separate count is
// what decides full/empty.
module div_req_fifo
    import div_pkg::*;
#(
    parameter int DEPTH = div_pkg::DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  req_t wdata,
    input  logic pop,
    output req_t rdata,
    output logic empty,
    output logic full_next
);

    localparam int AW = $clog2(DEPTH);

    req_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_next;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        cnt_next = cnt;
        case ({push_ok, pop_ok})
            2'b10:   cnt_next = cnt + 1'b1;
            2'b01:   cnt_next = cnt - 1'b1;
            default: cnt_next = cnt;    // idle, or push+pop leaves occupancy unchanged
        endcase
    end

    assign full_next = (cnt_next == (AW+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            cnt <= cnt_next;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage carries no reset; only the pointers/count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/div_operand_sequencer.sv
// div_operand_sequencer: front-end for the iterative division core.
// Buffers tagged divide requests, issues them one at a time to the core
// (start pulse + registered operands), waits for done and returns
// quotient/remainder/tag on the response channel.
//   i_clk, i_rst : rising-edge clock, synchronous active-high reset
//   bus          : div_operand_sequencer_if.slave (req / core / rsp signals)
//   dbg_state    : current FSM state, for observation only
// Optional feature: define DIV_ZERO_BYPASS_EN to answer divide-by-zero
// requests without the core (quotient all ones, remainder = dividend,
// o_rsp_div0 = 1). Without it every request goes to the core and
// o_rsp_div0 is tied 0.
module div_operand_sequencer
    import div_pkg::*;
#(
    parameter int DEPTH = div_pkg::DEPTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    div_operand_sequencer_if.slave  bus,
    output state_t                  dbg_state
);

    state_t            state_q;
    state_t            state_d;

    req_t              fifo_wdata;
    req_t              head;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full_next;

    logic              ready_q;
    logic              load_op;
    logic              cap_core;

    logic [DATA_W-1:0] op_dividend_q;
    logic [DATA_W-1:0] op_divisor_q;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] quot_q;
    logic [DATA_W-1:0] rem_q;

`ifdef DIV_ZERO_BYPASS_EN
    logic              bypass;
    logic              div0_q;
`endif

    // ---------------- request FIFO ----------------
    assign fifo_push  = bus.i_req_valid && ready_q;
    assign fifo_wdata = '{dividend: bus.i_req_dividend,
                          divisor:  bus.i_req_divisor,
                          tag:      bus.i_req_tag};

    div_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (fifo_push),
        .wdata     (fifo_wdata),
        .pop       (fifo_pop),
        .rdata     (head),
        .empty     (fifo_empty),
        .full_next (fifo_full_next)
    );

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        load_op  = 1'b0;
        cap_core = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
        bypass   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
                    if (head.divisor == '0) begin
                        bypass  = 1'b1;
                        state_d = RESP;
                    end else begin
                        load_op = 1'b1;
                        state_d = ISSUE;
                    end
`else
                    load_op = 1'b1;
                    state_d = ISSUE;
`endif
                end
            end
            // A done seen here belongs to nothing we issued; it is dropped.
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.i_core_done) begin
                    cap_core = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (bus.i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            ready_q       <= 1'b1;
            op_dividend_q <= '0;
            op_divisor_q  <= '0;
            tag_q         <= '0;
            quot_q        <= '0;
            rem_q         <= '0;
`ifdef DIV_ZERO_BYPASS_EN
            div0_q        <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            // Ready follows the occupancy after this edge; a pop cannot
            // reopen it in the same cycle.
            ready_q <= !fifo_full_next;
            if (load_op) begin
                op_dividend_q <= head.dividend;
                op_divisor_q  <= head.divisor;
            end
            if (fifo_pop) begin
                tag_q <= head.tag;
            end
            if (cap_core) begin
                quot_q <= bus.i_core_quotient;
                rem_q  <= bus.i_core_remainder;
`ifdef DIV_ZERO_BYPASS_EN
                div0_q <= 1'b0;
`endif
            end
`ifdef DIV_ZERO_BYPASS_EN
            if (bypass) begin
                quot_q <= '1;
                rem_q  <= head.dividend;
                div0_q <= 1'b1;
            end
`endif
        end
    end

    // ---------------- outputs ----------------
    assign bus.o_req_ready     = ready_q;
    assign bus.o_core_start    = (state_q == ISSUE);
    assign bus.o_core_dividend = op_dividend_q;
    assign bus.o_core_divisor  = op_divisor_q;
    assign bus.o_rsp_valid     = (state_q == RESP);
    assign bus.o_rsp_quotient  = quot_q;
    assign bus.o_rsp_remainder = rem_q;
    assign bus.o_rsp_tag       = tag_q;
`ifdef DIV_ZERO_BYPASS_EN
    assign bus.o_rsp_div0      = div0_q;
`else
    assign bus.o_rsp_div0      = 1'b0;
`endif
    assign dbg_state           = state_q;

endmodule

// File: tb/tb_div_operand_sequencer.sv
// tb_div_operand_sequencer: directed bench for div_operand_sequencer.
// A behavioural division core answers start pulses after core_lat cycles;
// a scoreboard queue holds the expected {div0, tag, quotient, remainder}
// of every accepted request and is compared whenever o_rsp_valid is high.
// Honours DIV_ZERO_BYPASS_EN for the divide-by-zero expectations.
module tb_div_operand_sequencer;
    import div_pkg::*;

    localparam int SB_W = 1 + TAG_W + 2 * DATA_W;

    typedef struct {
        logic [DATA_W-1:0] dividend;
        logic [DATA_W-1:0] divisor;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] exp_q;
        logic [DATA_W-1:0] exp_r;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dut_state;

    int tests = 0;
    int fails = 0;
    int starts = 0;
    int core_lat = 0;
    logic [SB_W-1:0] exp_q[$];
    vec_t vecs[8];
    logic exp_div0_zero;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    div_operand_sequencer_if sif ();

    div_operand_sequencer #(.DEPTH(4)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .bus       (sif.slave),
        .dbg_state (dut_state)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [SB_W-1:0] act, input logic [SB_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_req(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] eq,
                            input logic [DATA_W-1:0] er, input logic ediv0);
        bit ok = 1'b0;
        sif.i_req_valid    = 1'b1;
        sif.i_req_dividend = a;
        sif.i_req_divisor  = b;
        sif.i_req_tag      = t;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (sif.o_req_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        sif.i_req_valid = 1'b0;
        if (ok) begin
            exp_q.push_back({ediv0, t, eq, er});
        end else begin
            tests++;
            fails++;
            $display("FAIL req_accept_timeout: tag %0h not accepted within 400 cycles", t);
        end
    endtask

    task automatic wait_drain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && dut_state == IDLE) ok = 1'b1;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s_drain_timeout: %0d responses outstanding, expected 0", name, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural division core ----------------
    initial begin : core_model
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              pend;
        int                cnt;
        pend = 1'b0;
        cnt  = 0;
        a    = '0;
        b    = '0;
        sif.i_core_done      = 1'b0;
        sif.i_core_quotient  = '0;
        sif.i_core_remainder = '0;
        forever begin
            @(negedge clk);
            if (!rst && sif.o_core_start) begin
                starts++;
                pend = 1'b1;
                cnt  = core_lat;
            end
            // operands are re-sampled every cycle so an unstable operand
            // during the computation corrupts the result
            if (pend) begin
                a = sif.o_core_dividend;
                b = sif.o_core_divisor;
            end
            @(posedge clk);
            #1;
            sif.i_core_done = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    pend = 1'b0;
                    sif.i_core_done      = 1'b1;
                    sif.i_core_quotient  = (b == '0) ? '1 : a / b;
                    sif.i_core_remainder = (b == '0) ? a : a % b;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // ---------------- response scoreboard ----------------
    initial begin : rsp_monitor
        forever begin
            @(negedge clk);
            if (!rst && sif.o_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp_unexpected: got tag %0h q %0h r %0h, expected no response",
                             sif.o_rsp_tag, sif.o_rsp_quotient, sif.o_rsp_remainder);
                end else begin
                    check("rsp_fields",
                          {sif.o_rsp_div0, sif.o_rsp_tag, sif.o_rsp_quotient, sif.o_rsp_remainder},
                          exp_q[0]);
                    if (sif.i_rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int s0;
        int s1;
        bit seen;

`ifdef DIV_ZERO_BYPASS_EN
        exp_div0_zero = 1'b1;
`else
        exp_div0_zero = 1'b0;
`endif

        vecs[0] = '{dividend: 32'd5421,       divisor: 32'd3,   tag: 4'd5, exp_q: 32'd1807,       exp_r: 32'd0};
        vecs[1] = '{dividend: 32'd113,        divisor: 32'd2,   tag: 4'd1, exp_q: 32'd56,         exp_r: 32'd1};
        vecs[2] = '{dividend: 32'd100,        divisor: 32'd7,   tag: 4'd2, exp_q: 32'd14,         exp_r: 32'd2};
        vecs[3] = '{dividend: 32'd12345,      divisor: 32'd123, tag: 4'd3, exp_q: 32'd100,        exp_r: 32'd45};
        vecs[4] = '{dividend: 32'd7,          divisor: 32'd9,   tag: 4'd4, exp_q: 32'd0,          exp_r: 32'd7};
        vecs[5] = '{dividend: 32'hFFFFFFFF,   divisor: 32'd1,   tag: 4'd6, exp_q: 32'hFFFFFFFF,   exp_r: 32'd0};
        vecs[6] = '{dividend: 32'd65536,      divisor: 32'd256, tag: 4'd7, exp_q: 32'd256,        exp_r: 32'd0};
        vecs[7] = '{dividend: 32'd1000000,    divisor: 32'd999, tag: 4'd8, exp_q: 32'd1001,       exp_r: 32'd1};

        sif.i_req_valid    = 1'b0;
        sif.i_req_dividend = '0;
        sif.i_req_divisor  = '0;
        sif.i_req_tag      = '0;
        sif.i_rsp_ready    = 1'b1;

        // reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready",  sif.o_req_ready, 1'b1);
        check("reset_rsp_valid",  sif.o_rsp_valid, 1'b0);
        check("reset_core_start", sif.o_core_start, 1'b0);
        check("reset_state",      dut_state, IDLE);
        check("reset_core_ops",   {sif.o_core_dividend, sif.o_core_divisor}, '0);
        check("reset_rsp_fields", {sif.o_rsp_div0, sif.o_rsp_tag, sif.o_rsp_quotient, sif.o_rsp_remainder}, '0);
        @(posedge clk);
        #1;

        // single requests from the table, varying core latency
        for (int i = 0; i < 8; i++) begin
            core_lat = i % 3;
            s0 = starts;
            send_req(vecs[i].dividend, vecs[i].divisor, vecs[i].tag, vecs[i].exp_q, vecs[i].exp_r, 1'b0);
            wait_drain("table");
            check("table_start_count", starts - s0, 1);
        end

        // back-to-back: order preserved, one start each
        core_lat = 0;
        s0 = starts;
        send_req(32'd113, 32'd2, 4'd9,  32'd56, 32'd1, 1'b0);
        send_req(32'd100, 32'd7, 4'd10, 32'd14, 32'd2, 1'b0);
        wait_drain("b2b");
        check("b2b_start_count", starts - s0, 2);

        // fill: 1 in flight + 4 queued closes ready
        s0 = starts;
        sif.i_rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_req(vecs[i].dividend, vecs[i].divisor, vecs[i].tag, vecs[i].exp_q, vecs[i].exp_r, 1'b0);
        end
        repeat (4) @(negedge clk);
        check("fill_req_ready", sif.o_req_ready, 1'b0);
        check("fill_rsp_valid", sif.o_rsp_valid, 1'b1);
        check("fill_start_count", starts - s0, 1);
        @(posedge clk);
        #1;
        sif.i_rsp_ready = 1'b1;
        send_req(vecs[5].dividend, vecs[5].divisor, vecs[5].tag, vecs[5].exp_q, vecs[5].exp_r, 1'b0);
        wait_drain("fill");
        check("fill_total_starts", starts - s0, 6);

        // response held under backpressure; no new start meanwhile
        core_lat = 2;
        s0 = starts;
        sif.i_rsp_ready = 1'b0;
        send_req(32'd500, 32'd4,  4'd1, 32'd125, 32'd0, 1'b0);
        send_req(32'd999, 32'd10, 4'd2, 32'd99,  32'd9, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (sif.o_rsp_valid) seen = 1'b1;
        end
        check("hold_rsp_seen", seen, 1'b1);
        repeat (10) @(negedge clk);
        check("hold_rsp_valid", sif.o_rsp_valid, 1'b1);
        check("hold_no_new_start", starts - s0, 1);
        @(posedge clk);
        #1;
        sif.i_rsp_ready = 1'b1;
        wait_drain("hold");
        check("hold_total_starts", starts - s0, 2);

        // reset while waiting on the core; late done must be ignored
        core_lat = 3;
        send_req(32'd500, 32'd5, 4'd1, 32'd100, 32'd0, 1'b0);
        send_req(32'd600, 32'd6, 4'd2, 32'd100, 32'd0, 1'b0);
        send_req(32'd700, 32'd7, 4'd3, 32'd100, 32'd0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (dut_state == WAIT) seen = 1'b1;
        end
        check("rst_reached_wait", seen, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", sif.o_req_ready, 1'b1);
        check("rst_state_idle", dut_state, IDLE);
        check("rst_rsp_valid", sif.o_rsp_valid, 1'b0);
        s1 = starts;
        repeat (12) @(negedge clk);
        check("rst_fifo_discarded", starts - s1, 0);
        check("rst_state_after_late_done", dut_state, IDLE);
        @(posedge clk);
        #1;

        // divide by zero
        core_lat = 1;
        s0 = starts;
        send_req(32'd77, 32'd0, 4'd11, 32'hFFFFFFFF, 32'd77, exp_div0_zero);
        wait_drain("div0");
        check("div0_start_count", starts - s0, exp_div0_zero ? 0 : 1);

        // ordinary request after the zero-divisor case clears div0
        send_req(32'd81, 32'd9, 4'd12, 32'd9, 32'd0, 1'b0);
        wait_drain("after_div0");

        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
